idex_hazard_stage: RTL and testbench



---
 rtl/idex_hazard_stage_pkg.sv | 18 +
 rtl/idex_hazard_stage_load_use_detect.sv | 20 ++
 rtl/idex_hazard_stage.sv | 118 +++++++++++
 tb/tb_idex_hazard_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/idex_hazard_stage_pkg.sv
// idex_hazard_stage_pkg: shared control-bundle layout, ALU class encodings and register constants
package idex_hazard_stage_pkg;
  localparam int CTRL_W = 8;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
endpackage

// File: rtl/idex_hazard_stage_load_use_detect.sv
// load_use_detect: combinational load-use hazard detection and PC / IF-ID write enables
module load_use_detect
  import idex_hazard_stage_pkg::*;
(
  input  logic       mem_read_idex,
  input  logic       valid_idex,
  input  logic [4:0] rt_idex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       flush_id,
  output logic       hazard,
  output logic       pc_write,
  output logic       ifid_write
);
  always_comb begin
    hazard = mem_read_idex & valid_idex & (rt_idex != REG_ZERO) & ((rt_idex == rs_id) | (rt_idex == rt_id));
    pc_write = ~(hazard & ~flush_id);
    ifid_write = pc_write;
  end
endmodule

// File: rtl/idex_hazard_stage.sv
// idex_hazard_stage: ID/EX pipeline register with load-use bubble insertion and saturating stall counter
module idex_hazard_stage
  import idex_hazard_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc4_ID,
  input  logic [DATA_W-1:0] rdata1_ID,
  input  logic [DATA_W-1:0] rdata2_ID,
  input  logic [DATA_W-1:0] imm_ID,
  input  logic [4:0]        rs_ID,
  input  logic [4:0]        rt_ID,
  input  logic [4:0]        rd_ID,
  input  logic              reg_write_ID,
  input  logic              mem_to_reg_ID,
  input  logic              mem_read_ID,
  input  logic              mem_write_ID,
  input  logic              alu_src_ID,
  input  logic              reg_dst_ID,
  input  logic [1:0]        alu_op_ID,
  input  logic              flush_ID,
  output logic [DATA_W-1:0] pc4_IDEX,
  output logic [DATA_W-1:0] rdata1_IDEX,
  output logic [DATA_W-1:0] rdata2_IDEX,
  output logic [DATA_W-1:0] imm_IDEX,
  output logic [4:0]        rs_IDEX,
  output logic [4:0]        rt_IDEX,
  output logic [4:0]        rd_IDEX,
  output logic              reg_write_IDEX,
  output logic              mem_to_reg_IDEX,
  output logic              mem_read_IDEX,
  output logic              mem_write_IDEX,
  output logic              alu_src_IDEX,
  output logic              reg_dst_IDEX,
  output logic [1:0]        alu_op_IDEX,
  output logic              valid_IDEX,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_count
);
  logic [DATA_W-1:0] pc4_q, pc4_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
  logic [4:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  ctrl_t ctrl_q, ctrl_d, ctrl_id;
  logic valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic hazard, bubble;
  load_use_detect u_detect (
    .mem_read_idex(ctrl_q.mem_read),
    .valid_idex   (valid_q),
    .rt_idex      (rt_q),
    .rs_id        (rs_ID),
    .rt_id        (rt_ID),
    .flush_id     (flush_ID),
    .hazard       (hazard),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write)
  );
  always_comb begin
    ctrl_id = '{reg_write: reg_write_ID, mem_to_reg: mem_to_reg_ID, mem_read: mem_read_ID,
                mem_write: mem_write_ID, alu_src: alu_src_ID, reg_dst: reg_dst_ID, alu_op: alu_op_ID};
    bubble = flush_ID | hazard;
    pc4_d = pc4_ID;
    rdata1_d = rdata1_ID;
    rdata2_d = rdata2_ID;
    imm_d = imm_ID;
    rs_d = rs_ID;
    rt_d = rt_ID;
    rd_d = rd_ID;
    ctrl_d = bubble ? CTRL_NOP : ctrl_id;
    valid_d = ~bubble;
    // a flushed instruction never needed the stall, so it is not counted
    cnt_d = (hazard & ~flush_ID & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc4_q <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rd_q <= '0;
      ctrl_q <= CTRL_NOP;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc4_q <= pc4_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      imm_q <= imm_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      rd_q <= rd_d;
      ctrl_q <= ctrl_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign pc4_IDEX = pc4_q;
  assign rdata1_IDEX = rdata1_q;
  assign rdata2_IDEX = rdata2_q;
  assign imm_IDEX = imm_q;
  assign rs_IDEX = rs_q;
  assign rt_IDEX = rt_q;
  assign rd_IDEX = rd_q;
  assign reg_write_IDEX = ctrl_q.reg_write;
  assign mem_to_reg_IDEX = ctrl_q.mem_to_reg;
  assign mem_read_IDEX = ctrl_q.mem_read;
  assign mem_write_IDEX = ctrl_q.mem_write;
  assign alu_src_IDEX = ctrl_q.alu_src;
  assign reg_dst_IDEX = ctrl_q.reg_dst;
  assign alu_op_IDEX = ctrl_q.alu_op;
  assign valid_IDEX = valid_q;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_idex_hazard_stage.sv
// tb_idex_hazard_stage: directed vectors with a scoreboard queue checked by an independent monitor
module tb_idex_hazard_stage;
  localparam logic [7:0] ADD = 8'h86, LW = 8'hE8, SW = 8'h18;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] pc4_ID = '0, rdata1_ID = '0, rdata2_ID = '0, imm_ID = '0;
  logic [4:0] rs_ID = '0, rt_ID = '0, rd_ID = '0;
  logic reg_write_ID = 0, mem_to_reg_ID = 0, mem_read_ID = 0, mem_write_ID = 0, alu_src_ID = 0, reg_dst_ID = 0;
  logic [1:0] alu_op_ID = '0;
  logic flush_ID = 0;
  logic [31:0] pc4_IDEX, rdata1_IDEX, rdata2_IDEX, imm_IDEX;
  logic [4:0] rs_IDEX, rt_IDEX, rd_IDEX;
  logic reg_write_IDEX, mem_to_reg_IDEX, mem_read_IDEX, mem_write_IDEX, alu_src_IDEX, reg_dst_IDEX;
  logic [1:0] alu_op_IDEX;
  logic valid_IDEX, pc_write, ifid_write;
  logic [1:0] stall_count;
  int errors = 0;
  int checks = 0;
  logic [31:0] n = '0;

  typedef struct {
    logic chk;
    logic pw;
    logic v;
    logic [7:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic [31:0] pc4, r1, r2, imm;
    logic [1:0] cnt;
  } exp_t;
  exp_t q[$];

  idex_hazard_stage #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .pc4_ID(pc4_ID), .rdata1_ID(rdata1_ID), .rdata2_ID(rdata2_ID), .imm_ID(imm_ID),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
    .reg_write_ID(reg_write_ID), .mem_to_reg_ID(mem_to_reg_ID), .mem_read_ID(mem_read_ID),
    .mem_write_ID(mem_write_ID), .alu_src_ID(alu_src_ID), .reg_dst_ID(reg_dst_ID),
    .alu_op_ID(alu_op_ID), .flush_ID(flush_ID),
    .pc4_IDEX(pc4_IDEX), .rdata1_IDEX(rdata1_IDEX), .rdata2_IDEX(rdata2_IDEX), .imm_IDEX(imm_IDEX),
    .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX), .rd_IDEX(rd_IDEX),
    .reg_write_IDEX(reg_write_IDEX), .mem_to_reg_IDEX(mem_to_reg_IDEX), .mem_read_IDEX(mem_read_IDEX),
    .mem_write_IDEX(mem_write_IDEX), .alu_src_IDEX(alu_src_IDEX), .reg_dst_IDEX(reg_dst_IDEX),
    .alu_op_IDEX(alu_op_IDEX), .valid_IDEX(valid_IDEX),
    .pc_write(pc_write), .ifid_write(ifid_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // r=reset, fl=flush, c=control bundle; chk/epw = check pc_write this cycle; ev/ecnt = state after the edge
  task automatic step(input logic r, input logic fl, input logic [7:0] c, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic chk, input logic epw,
                      input logic ev, input logic [1:0] ecnt);
    exp_t e;
    @(negedge clk);
    n = n + 1;
    rst = r;
    flush_ID = fl;
    {reg_write_ID, mem_to_reg_ID, mem_read_ID, mem_write_ID, alu_src_ID, reg_dst_ID, alu_op_ID} = c;
    rs_ID = rs; rt_ID = rt; rd_ID = rd;
    pc4_ID = 32'h0040_0000 + n * 4;
    rdata1_ID = 32'hA000_0000 + n;
    rdata2_ID = 32'hB000_0000 + n;
    imm_ID = 32'hC000_0000 + n;
    e.chk = chk;
    e.pw = epw;
    e.v = ev;
    e.ctrl = (r || !ev) ? 8'h00 : c;
    e.rs = r ? 5'd0 : rs;
    e.rt = r ? 5'd0 : rt;
    e.rd = r ? 5'd0 : rd;
    e.pc4 = r ? 32'd0 : pc4_ID;
    e.r1 = r ? 32'd0 : rdata1_ID;
    e.r2 = r ? 32'd0 : rdata2_ID;
    e.imm = r ? 32'd0 : imm_ID;
    e.cnt = ecnt;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic pw, iw;
    forever begin
      @(negedge clk);
      #2;
      pw = pc_write;
      iw = ifid_write;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("pc_write", 32'(pw), 32'(e.pw));
          check("ifid_write", 32'(iw), 32'(e.pw));
        end
        check("valid_IDEX", 32'(valid_IDEX), 32'(e.v));
        check("ctrl_IDEX", 32'({reg_write_IDEX, mem_to_reg_IDEX, mem_read_IDEX, mem_write_IDEX,
                               alu_src_IDEX, reg_dst_IDEX, alu_op_IDEX}), 32'(e.ctrl));
        check("rs_IDEX", 32'(rs_IDEX), 32'(e.rs));
        check("rt_IDEX", 32'(rt_IDEX), 32'(e.rt));
        check("rd_IDEX", 32'(rd_IDEX), 32'(e.rd));
        check("pc4_IDEX", pc4_IDEX, e.pc4);
        check("rdata1_IDEX", rdata1_IDEX, e.r1);
        check("rdata2_IDEX", rdata2_IDEX, e.r2);
        check("imm_IDEX", imm_IDEX, e.imm);
        check("stall_count", 32'(stall_count), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    //    rst fl  ctrl rs  rt  rd  chk pw v  cnt
    step(1, 0, ADD, 2, 3, 4, 0, 1, 0, 0);
    step(1, 0, ADD, 2, 3, 4, 1, 1, 0, 0);
    step(0, 0, ADD, 2, 3, 4, 1, 1, 1, 0);
    step(0, 0, LW, 1, 5, 0, 1, 1, 1, 0);
    step(0, 0, ADD, 5, 6, 7, 1, 0, 0, 1);
    step(0, 0, ADD, 5, 6, 7, 1, 1, 1, 1);
    step(0, 0, LW, 0, 0, 0, 1, 1, 1, 1);
    step(0, 0, ADD, 0, 0, 8, 1, 1, 1, 1);
    step(0, 0, LW, 1, 7, 0, 1, 1, 1, 1);
    step(0, 1, SW, 2, 7, 0, 1, 1, 0, 1);
    step(0, 0, LW, 3, 9, 0, 1, 1, 1, 1);
    step(0, 0, LW, 9, 10, 0, 1, 0, 0, 2);
    step(0, 0, LW, 9, 10, 0, 1, 1, 1, 2);
    step(0, 0, LW, 10, 11, 0, 1, 0, 0, 3);
    step(0, 0, LW, 10, 11, 0, 1, 1, 1, 3);
    step(0, 0, ADD, 11, 11, 1, 1, 0, 0, 3);
    step(0, 0, ADD, 11, 11, 1, 1, 1, 1, 3);
    step(0, 0, LW, 1, 12, 0, 1, 1, 1, 3);
    step(0, 0, ADD, 4, 12, 2, 1, 0, 0, 3);
    step(0, 0, ADD, 4, 12, 2, 1, 1, 1, 3);
    step(0, 0, LW, 0, 13, 0, 1, 1, 1, 3);
    step(1, 0, ADD, 13, 1, 3, 1, 0, 0, 0);
    step(0, 0, ADD, 13, 1, 3, 1, 1, 1, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
